// File: rtl/i2c_write_master_if.sv
// Request/response handshake between the codec configuration sequencer and
// the I2C write master: transaction word and go in, end/ack/busy back.
interface i2c_write_master_if;
  logic [23:0] i2c_data;
  logic        go;
  logic        end_o;
  logic [2:0]  ack;
  logic        busy;

  modport master (output i2c_data, go, input end_o, ack, busy);
  modport slave  (input i2c_data, go, output end_o, ack, busy);
endinterface

// File: rtl/i2c_write_master.sv
// Bit-level I2C master: one START, three bytes with ACK slots, one STOP per go.
// Each slot is four phases of PHASE_CYCLES clocks; pin outputs are registered.
module i2c_write_master #(
  parameter int PHASE_CYCLES  = 1,
  parameter bit ABORT_ON_NACK = 1'b0
) (
  input  logic              clk_i2c,
  input  logic              reset_n,
  i2c_write_master_if.slave bus,
  output logic              i2c_sclk,
  inout  wire               i2c_sdat
);
  localparam int CW = $clog2(PHASE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   sr_q, sr_d;
  logic [2:0]    ack_q, ack_d;
  logic          busy_q, busy_d, end_q, end_d;
  logic          scl_q, scl_d, sda_low_q, sda_low_d;
  logic          tick, slot_end;

  assign tick     = (div_q == CW'(PHASE_CYCLES - 1));
  assign slot_end = tick && (phase_q == 2'd3);

  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      phase_q   <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      sr_q      <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      scl_q     <= 1'b1;
      sda_low_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sr_q      <= sr_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      end_q     <= end_d;
      scl_q     <= scl_d;
      sda_low_q <= sda_low_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sr_d    = sr_q;
    ack_d   = ack_q;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) phase_d = phase_q + 2'd1;
    end

    case (state_q)
      S_IDLE: if (bus.go) begin
        state_d = S_START;
        sr_d    = bus.i2c_data;
        ack_d   = '0;
        div_d   = '0;
        phase_d = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
      S_START: if (slot_end) state_d = S_DATA;
      S_DATA: if (slot_end) begin
        sr_d  = {sr_q[22:0], 1'b0};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_ACK;
      end
      S_ACK: begin
        // sampled on the last edge of P2, while SCL has been high a full phase
        if (tick && phase_q == 2'd2) ack_d[2'd2 - byte_q] = i2c_sdat;
        if (slot_end) begin
          if (byte_q == 2'd2 || (ABORT_ON_NACK && ack_q[2'd2 - byte_q])) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
            byte_d  = byte_q + 2'd1;
          end
        end
      end
      S_STOP: if (slot_end) state_d = S_DONE;
      S_DONE: if (!bus.go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin levels are decoded from the upcoming state so each phase's registered
  // value is on the pins for exactly that phase.
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      S_START: begin
        scl_d     = (phase_d != 2'd3);
        sda_low_d = (phase_d != 2'd0);
      end
      S_DATA: begin
        scl_d     = phase_d[1];
        sda_low_d = (phase_d == 2'd1) ? !sr_d[23] : sda_low_q;
      end
      S_ACK: begin
        scl_d     = phase_d[1];
        sda_low_d = (phase_d == 2'd0) ? sda_low_q : 1'b0;
      end
      S_STOP: begin
        scl_d     = phase_d[1];
        sda_low_d = (phase_d != 2'd3);
      end
      default: ;
    endcase
    busy_d = state_d inside {S_START, S_DATA, S_ACK, S_STOP};
    // first DONE cycle always raises end; a held end drops as soon as go is low
    end_d  = (state_q == S_DONE) && (bus.go || !end_q);
  end

  assign i2c_sclk  = scl_q;
  assign i2c_sdat  = sda_low_q ? 1'b0 : 1'bz;
  assign bus.end_o = end_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench: three masters (PC=1 no-abort, PC=1 abort, PC=3) with an ACK/NACK
// slave model and a bus monitor counting SCL rises and SDA edges while SCL is high.
module tb_i2c_write_master;
  logic clk_i2c = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_i2c = ~clk_i2c;

  int cyc = 0;
  always @(posedge clk_i2c) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  logic        go_tb   [3];
  logic [23:0] data_tb [3];
  logic [2:0]  nack_tb [3];
  wire         end_w   [3];
  wire         busy_w  [3];
  wire         scl_w   [3];
  wire         sda_w   [3];
  wire  [2:0]  ack_w   [3];
  wire  [31:0] rise_w  [3];
  wire  [31:0] hfall_w [3];
  wire  [31:0] hrise_w [3];
  wire  [31:0] per_w   [3];
  wire  [31:0] bits_w  [3];

  for (genvar i = 0; i < 3; i++) begin : g
    i2c_write_master_if bus ();
    wire  sda;
    wire  scl;
    logic drv = 1'b0;
    pullup (sda);
    assign sda = drv ? 1'b0 : 1'bz;
    assign bus.go       = go_tb[i];
    assign bus.i2c_data = data_tb[i];

    i2c_write_master #(
      .PHASE_CYCLES  (i == 2 ? 3 : 1),
      .ABORT_ON_NACK (i == 1 ? 1'b1 : 1'b0)
    ) dut (
      .clk_i2c  (clk_i2c),
      .reset_n  (reset_n),
      .bus      (bus),
      .i2c_sclk (scl),
      .i2c_sdat (sda)
    );

    // slave: after the SCL fall that opens slot k, pull SDA low for ACK slots (k%9==8)
    int   falls = 0;
    logic scl_s = 1'b1;
    always @(posedge clk_i2c) begin
      scl_s <= scl;
      if (!bus.busy) begin
        falls <= 0;
        drv   <= 1'b0;
      end else if (scl_s && !scl) begin
        falls <= falls + 1;
        drv   <= (falls % 9 == 8) ? !nack_tb[i][2 - falls / 9] : 1'b0;
      end
    end

    logic        scl_p = 1'b1;
    logic        sda_p = 1'b1;
    int          rises = 0, hfall = 0, hrise = 0, per = 0, last = 0;
    logic [31:0] bits = '0;
    always @(negedge clk_i2c) begin
      scl_p <= scl;
      sda_p <= sda;
      if (!scl_p && scl) begin
        rises <= rises + 1;
        per   <= cyc - last;
        last  <= cyc;
        bits  <= {bits[30:0], sda};
      end
      if (scl_p && scl && sda_p && !sda) hfall <= hfall + 1;
      if (scl_p && scl && !sda_p && sda) hrise <= hrise + 1;
    end

    assign end_w[i]   = bus.end_o;
    assign busy_w[i]  = bus.busy;
    assign ack_w[i]   = bus.ack;
    assign scl_w[i]   = scl;
    assign sda_w[i]   = sda;
    assign rise_w[i]  = rises;
    assign hfall_w[i] = hfall;
    assign hrise_w[i] = hrise;
    assign per_w[i]   = per;
    assign bits_w[i]  = bits;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int r0, f0, h0;
  task automatic snap(input int i);
    r0 = rise_w[i];
    f0 = hfall_w[i];
    h0 = hrise_w[i];
  endtask

  task automatic chk_bus(input int i, input int nrise);
    chk("scl_rises",   rise_w[i] - r0, nrise);
    chk("start_edges", hfall_w[i] - f0, 1);
    chk("stop_edges",  hrise_w[i] - h0, 1);
  endtask

  // n = edges after the go-sampling edge until end_o seen; bcnt = cycles busy high
  task automatic run_xfer(input int i, input logic [23:0] d, input int lim,
                          output int n, output int bcnt);
    data_tb[i] = d;
    go_tb[i]   = 1'b1;
    @(negedge clk_i2c);
    chk("busy_rise", busy_w[i], 1);
    n = 0;
    bcnt = 1;
    while (end_w[i] !== 1'b1 && n < lim) begin
      @(negedge clk_i2c);
      n++;
      if (busy_w[i] === 1'b1) bcnt++;
    end
  endtask

  initial begin
    int n, bcnt;
    logic [27:0] exp28;
    logic [9:0]  exp10;
    for (int i = 0; i < 3; i++) begin
      go_tb[i]   = 1'b0;
      data_tb[i] = '0;
      nack_tb[i] = '0;
    end
    repeat (3) @(negedge clk_i2c);
    chk("rst_scl",  scl_w[0], 1);
    chk("rst_sda",  sda_w[0], 1);
    chk("rst_busy", busy_w[0], 0);
    chk("rst_end",  end_w[0], 0);
    chk("rst_ack",  ack_w[0], 3'b000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_i2c);

    // single write, all ACK
    snap(0);
    run_xfer(0, 24'h341E00, 400, n, bcnt);
    chk("lat_full", n, 117);
    chk("busy_len", bcnt, 116);
    chk("ack_all",  ack_w[0], 3'b000);
    chk_bus(0, 28);
    exp28 = {8'h34, 1'b0, 8'h1E, 1'b0, 8'h00, 1'b0, 1'b0};
    chk("bits_341E00", bits_w[0][27:0], exp28);

    // handshake: end_o held while go stays high, no new START
    snap(0);
    repeat (20) @(negedge clk_i2c);
    chk("hold_end",   end_w[0], 1);
    chk("hold_busy",  busy_w[0], 0);
    chk("hold_rises", rise_w[0] - r0, 0);
    chk("hold_start", hfall_w[0] - f0, 0);
    go_tb[0] = 1'b0;
    @(negedge clk_i2c);
    chk("end_clear", end_w[0], 0);

    // second transfer, slave NACKs byte 1, no abort
    nack_tb[0] = 3'b010;
    snap(0);
    run_xfer(0, 24'h340C00, 400, n, bcnt);
    chk("lat_nack", n, 117);
    chk("ack_nack1", ack_w[0], 3'b010);
    chk_bus(0, 28);
    exp28 = {8'h34, 1'b0, 8'h0C, 1'b1, 8'h00, 1'b0, 1'b0};
    chk("bits_340C00", bits_w[0][27:0], exp28);
    go_tb[0] = 1'b0;
    repeat (3) @(negedge clk_i2c);
    chk("ack_kept_idle", ack_w[0], 3'b010);

    // abort on address NACK
    nack_tb[1] = 3'b100;
    snap(1);
    run_xfer(1, 24'h341E00, 400, n, bcnt);
    chk("lat_abort",  n, 45);
    chk("busy_abort", bcnt, 44);
    chk("ack_abort",  ack_w[1], 3'b100);
    chk_bus(1, 10);
    exp10 = {8'h34, 1'b1, 1'b0};
    chk("bits_abort", bits_w[1][9:0], exp10);
    go_tb[1] = 1'b0;
    repeat (3) @(negedge clk_i2c);

    // go dropped mid-transfer on the abort master, all bytes ACKed: end_o pulses once
    nack_tb[1] = 3'b000;
    snap(1);
    data_tb[1] = 24'h12AB56;
    go_tb[1]   = 1'b1;
    @(negedge clk_i2c);
    n = 0;
    repeat (5) begin @(negedge clk_i2c); n++; end
    go_tb[1] = 1'b0;
    while (end_w[1] !== 1'b1 && n < 400) begin @(negedge clk_i2c); n++; end
    chk("lat_godrop", n, 117);
    @(negedge clk_i2c);
    chk("end_pulse", end_w[1], 0);
    chk("ack_godrop", ack_w[1], 3'b000);
    chk_bus(1, 28);
    exp28 = {8'h12, 1'b0, 8'hAB, 1'b0, 8'h56, 1'b0, 1'b0};
    chk("bits_12AB56", bits_w[1][27:0], exp28);

    // PHASE_CYCLES=3, NACK on data byte
    nack_tb[2] = 3'b001;
    snap(2);
    run_xfer(2, 24'h341E00, 1000, n, bcnt);
    chk("lat_pc3",  n, 349);
    chk("busy_pc3", bcnt, 348);
    chk("ack_pc3",  ack_w[2], 3'b001);
    chk("scl_period_pc3", per_w[2], 12);
    chk_bus(2, 28);
    go_tb[2] = 1'b0;
    repeat (3) @(negedge clk_i2c);

    // reset during byte 1 bit 4 (SCL low phase)
    nack_tb[0] = 3'b100;
    data_tb[0] = 24'h341E00;
    go_tb[0]   = 1'b1;
    @(negedge clk_i2c);
    repeat (57) @(negedge clk_i2c);
    chk("pre_rst_ack",  ack_w[0], 3'b100);
    chk("pre_rst_scl",  scl_w[0], 0);
    chk("pre_rst_busy", busy_w[0], 1);
    reset_n  = 1'b0;
    go_tb[0] = 1'b0;
    #1;
    chk("mid_rst_scl",  scl_w[0], 1);
    chk("mid_rst_sda",  sda_w[0], 1);
    chk("mid_rst_busy", busy_w[0], 0);
    chk("mid_rst_end",  end_w[0], 0);
    chk("mid_rst_ack",  ack_w[0], 3'b000);
    repeat (2) @(negedge clk_i2c);
    reset_n = 1'b1;
    snap(0);
    repeat (10) @(negedge clk_i2c);
    chk("post_rst_busy",  busy_w[0], 0);
    chk("post_rst_scl",   scl_w[0], 1);
    chk("post_rst_end",   end_w[0], 0);
    chk("post_rst_rises", rise_w[0] - r0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Bit-level I2C master that executes one 3-byte write transaction (slave address, sub-address, data) per request.
- Runs on the 10 kHz clk_i2c.
- Sits directly downstream of the audio codec configuration sequencer: it consumes the {addr, reg, data} word plus the go strobe, drives SCLK/SDAT to the WM8731, and returns end and per-byte acknowledge status.

Parameters:
- PHASE_CYCLES, 1, clk_i2c cycles per quarter-bit phase (SCL period = 4*PHASE_CYCLES cycles); must be >= 1.
- ABORT_ON_NACK, 0, 1: a NACK on any byte skips the remaining bytes and goes straight to STOP; 0: always send all 3 bytes.

Ports:
- clk_i2c   input   1   controller clock (10 kHz)
- reset_n   input   1   reset, asynchronous, active-low
- i2c_data  input   24  transaction word {slave_addr[7:0], sub_addr[7:0], data[7:0]}, sent MSB first
- go        input   1   level request; sampled in IDLE
- end_o     output  1   transaction complete; held while go=1
- ack       output  3   sampled ACK bits: [2]=byte0, [1]=byte1, [0]=byte2; 0=ACK, 1=NACK
- busy      output  1   high from START through STOP
- i2c_sclk  output  1   I2C clock, push-pull, registered
- i2c_sdat  inout   1   I2C data, open-drain: drive 0 or Z

Behaviour:
- Reset (async, any state): state=IDLE, i2c_sclk=1, SDA released (Z), end_o=0, busy=0, ack=3'b000, shift register and counters=0. A transfer in progress is abandoned immediately.
- All outputs are registered. The phase tick advances every PHASE_CYCLES clk_i2c cycles. Each slot has 4 phases, P0..P3.
- IDLE: SCL=1, SDA=Z. If go=1, latch i2c_data into a 24-bit shift register, clear ack to 000, set busy=1, go to START.
- START:
  - P0: SCL=1, SDA=Z.
  - P1, P2: SCL=1, SDA=0.
  - P3: SCL=0, SDA=0.
  - Then go to DATA, bit 7 of byte 0.
- DATA slot:
  - P0: SCL=0, SDA holds its previous value.
  - P1: SCL=0, SDA = shift-register MSB (0 drives low, 1 gives Z).
  - P2, P3: SCL=1.
  - At the end of P3, shift left. After 8 bits go to ACK.
- ACK slot: same phases with SDA=Z from P1.
  - The i2c_sdat input is sampled on the last clk_i2c edge of P2 into ack[2-byte_idx].
  - Next state: DATA of next byte, or STOP after byte 2.
  - If ABORT_ON_NACK=1 and the sampled bit=1, go to STOP directly; remaining ack bits stay 0.
- STOP:
  - P0, P1: SCL=0, SDA=0.
  - P2: SCL=1, SDA=0.
  - P3: SCL=1, SDA=Z.
  - Then DONE.
- DONE: busy=0, end_o=1, SCL=1, SDA=Z. When go=0, clear end_o and return to IDLE (one cycle later). A new transfer requires go to be seen low, then high.
- Latency with PHASE_CYCLES=1, full transfer: 4 (START) + 27*4 (24 data + 3 ack slots) + 4 (STOP) = 116 cycles. end_o rises on the 117th rising edge after the edge that samples go=1.
- SDA changes only while SCL=0, except the START and STOP edges.
- i2c_data changes after the latch edge do not affect the transfer in flight.
- go dropping mid-transfer is ignored. The transfer completes, and DONE exits on the first cycle since go is already 0 (end_o pulses for 1 cycle).
- Arithmetic: bit counter 3 bits, wraps 7→0 into the ACK slot. Byte index 2 bits, 0..2. Phase-divider counter is ceil(log2(PHASE_CYCLES+1)) bits.

Test Plan:
- Single write: PHASE_CYCLES=1, i2c_data=24'h341E00, bus model ACKs all bytes, go held until end_o → SDA bit sequence 00110100 A 00011110 A 00000000 A bracketed by START/STOP; ack=000; end_o at edge 117; busy high for exactly 116 cycles.
- NACK, no abort: ABORT_ON_NACK=0, slave NACKs byte 1 only → all 27 slots clocked; ack=3'b010; end_o at edge 117.
- NACK, abort: ABORT_ON_NACK=1, slave NACKs byte 0 (address) → STOP immediately after first ACK slot; ack=3'b100; end_o after 4+9*4+4=44 cycles +1.
- Handshake: after end_o, keep go=1 for 20 cycles → end_o stays 1, no new START. Drop go → end_o=0 next edge. Raise go again with 24'h340C00 → second transfer starts.
- Reset mid-operation: assert reset_n=0 during byte 1 bit 4 → same clock: SCL=1, SDA=Z, busy=0, end_o=0, ack=000. After release with go=0, stays IDLE.
- Timing/protocol checker (all scenarios, plus PHASE_CYCLES=3): SDA never changes while SCL=1 except the START falling edge and the STOP rising edge; SCL period = 12 cycles when PHASE_CYCLES=3.
